wb_sram_bist_master: RTL
========================

WB_SRAM_BIST_MASTER -- requirements
Module: wb_sram_bist_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, byte address of word 0 of the target memory.
REQ-002 SHALL have parameter WORDS, default 1024, number of 32-bit words tested (range 1..65536).
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles stb may wait for ack (used only with REQ-034).
REQ-004 SHALL have ports, clock and reset first; one clock, reset synchronous and active-high:
  wb_clk_i  in  1  system clock, all logic on rising edge
  wb_rst_i  in  1  synchronous active-high reset
  start_i  in  1  start test pulse/level, sampled in IDLE or DONE
  pattern_i  in  32  seed pattern, captured on accepted start
  wbm_cyc_o  out  1  Wishbone master cycle
  wbm_stb_o  out  1  Wishbone master strobe
  wbm_we_o  out  1  1 = write, 0 = read
  wbm_sel_o  out  4  byte selects
  wbm_adr_o  out  32  byte address
  wbm_dat_o  out  32  write data
  wbm_ack_i  in  1  slave acknowledge
  wbm_dat_i  in  32  slave read data
  busy_o  out  1  test in progress
  done_o  out  1  test finished (level)
  pass_o  out  1  1 = no mismatch, no timeout; valid when done_o=1
  timeout_o  out  1  test aborted by ack timeout
  err_count_o  out  16  read mismatches, saturating
  fail_addr_o  out  32  byte address of first mismatch

Function
REQ-005 SHALL implement FSM states IDLE, WRITE, WGAP, READ, RGAP, DONE.
REQ-006 SHALL, in IDLE or DONE with start_i=1, capture pattern_i, clear index, err_count_o, fail_addr_o, done_o, pass_o, timeout_o, and enter WRITE next cycle.
REQ-007 SHALL ignore start_i in all other states.
REQ-008 SHALL, for word index i, drive wbm_adr_o = BASE_ADDR + 4*i and expected/write data = seed XOR i (i zero-extended to 32 bits).
REQ-009 SHALL in WRITE assert cyc=1, stb=1, we=1, sel=4'hF and hold adr/dat stable until the cycle wbm_ack_i=1.
REQ-010 SHALL on the write ack cycle go to WGAP, dropping cyc and stb for exactly one cycle; WGAP increments i, enters READ with i=0 if the last word was WORDS-1, else WRITE.
REQ-011 SHALL in READ assert cyc=1, stb=1, we=0, sel=4'hF, hold adr stable until ack.
REQ-012 SHALL compare wbm_dat_i against expected on the read ack cycle only.
REQ-013 SHALL on mismatch increment err_count_o, saturating at 16'hFFFF, and load fail_addr_o only if err_count_o was 0.
REQ-014 SHALL on read ack go to RGAP (cyc=stb=0, one cycle); RGAP enters DONE after word WORDS-1, else READ with i+1.
REQ-015 SHALL in DONE set done_o=1, pass_o=(err_count_o==0 && !timeout_o), hold results until next accepted start or reset.
REQ-016 SHALL drive busy_o=1 exactly in WRITE, WGAP, READ, RGAP.
REQ-017 SHALL drive wbm_stb_o=1 only when wbm_cyc_o=1; outside WRITE/READ cyc, stb, we, sel=0 and adr, dat=0.
REQ-018 SHALL ignore wbm_ack_i when stb=0.
REQ-019 SHALL take 2*WORDS*(L+1)+2 cycles from accepted start to done_o=1, where L = cycles from stb rise to ack (L>=1).

Reset
REQ-020 SHALL on wb_rst_i=1 at a clock edge enter IDLE; all outputs 0 from that edge, including mid-transaction (cyc/stb drop without waiting for ack).
REQ-021 SHALL give reset priority over start_i and wbm_ack_i.

Configuration
REQ-034 SHALL, when WB_BIST_TIMEOUT_EN is defined, count cycles with stb=1 and no ack; on reaching TIMEOUT drop cyc/stb next edge, set timeout_o=1, enter DONE with pass_o=0.
REQ-035 SHALL, when WB_BIST_TIMEOUT_EN is undefined, wait indefinitely for ack, tie timeout_o to 0, and contain no timeout counter.

Verification (WORDS=4, BASE_ADDR=32'h3000_0000)
REQ-040 Ideal slave, ack L=1, pattern 32'hA5A5_0000 -> writes 0xA5A50000..0xA5A50003 to 0x30000000..0x3000000C; done_o after 18 cycles; pass_o=1, err_count_o=0.
REQ-041 Slave corrupts word 2 read (bit 0 flipped) -> err_count_o=1, fail_addr_o=32'h3000_0008, pass_o=0.
REQ-042 Slave acks after L=3 with random stall -> adr/dat/we stable while stb=1 without ack; done after 34 cycles; pass_o=1.
REQ-043 wb_rst_i pulsed during second READ -> next edge cyc=stb=busy_o=done_o=0, state IDLE; start_i then restarts, pass_o=1.
REQ-044 start_i held high during test -> ignored; after done_o with start_i=1 test restarts, done_o clears.
REQ-045 WB_BIST_TIMEOUT_EN, TIMEOUT=8, slave never acks -> cyc/stb drop after 8 stalled cycles, timeout_o=1, done_o=1, pass_o=0; without macro bus stays in WRITE.

Source files
------------

// File: rtl/wb_sram_bist_master.sv
// Wishbone master that writes seed^index to WORDS words, reads them back and reports mismatches.
// Define WB_BIST_TIMEOUT_EN to abort a stalled bus cycle after TIMEOUT cycles without ack.
module wb_sram_bist_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned WORDS     = 1024,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [31:0] pattern_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [31:0] fail_addr_o
);

  typedef enum logic [2:0] {IDLE, WRITE, WGAP, READ, RGAP, DONE} state_t;

  localparam logic [16:0] LAST_IDX = 17'(WORDS - 1);

  state_t      state_reg;
  logic [31:0] seed_reg;
  logic [16:0] idx_reg;
  logic        cyc_reg, stb_reg, we_reg;
  logic [3:0]  sel_reg;
  logic [31:0] adr_reg, dat_reg;
  logic        done_reg, pass_reg, timeout_reg;
  logic [15:0] err_reg;
  logic [31:0] fail_reg;

  logic        ack_seen;
  logic        last_word;
  logic [16:0] idx_inc;
  logic        wait_expired;

  function automatic logic [31:0] word_adr(input logic [16:0] idx);
    return BASE_ADDR + {13'd0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] word_dat(input logic [31:0] seed, input logic [16:0] idx);
    return seed ^ {15'd0, idx};
  endfunction

  assign ack_seen  = stb_reg & wbm_ack_i;
  assign last_word = (idx_reg == LAST_IDX);
  assign idx_inc   = idx_reg + 17'd1;

`ifdef WB_BIST_TIMEOUT_EN
  logic [31:0] wait_reg;

  // Counts cycles the current strobe has been outstanding without ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !stb_reg || wbm_ack_i) wait_reg <= '0;
    else                                    wait_reg <= wait_reg + 32'd1;
  end

  assign wait_expired = stb_reg && !wbm_ack_i && (wait_reg == 32'(TIMEOUT - 1));
  assign timeout_o    = timeout_reg;
`else
  assign wait_expired = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
      seed_reg  <= '0;
      idx_reg   <= '0;
      {cyc_reg, stb_reg, we_reg, sel_reg, adr_reg, dat_reg} <= '0;
      {done_reg, pass_reg, timeout_reg} <= '0;
      err_reg   <= '0;
      fail_reg  <= '0;
    end else if (wait_expired) begin
      {cyc_reg, stb_reg, we_reg, sel_reg, adr_reg, dat_reg} <= '0;
      timeout_reg <= 1'b1;
      done_reg    <= 1'b1;
      pass_reg    <= 1'b0;
      state_reg   <= DONE;
    end else begin
      unique case (state_reg)
        IDLE, DONE: begin
          if (start_i) begin
            seed_reg  <= pattern_i;
            idx_reg   <= '0;
            err_reg   <= '0;
            fail_reg  <= '0;
            {done_reg, pass_reg, timeout_reg} <= '0;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          if (ack_seen) begin
            {cyc_reg, stb_reg, we_reg, sel_reg, adr_reg, dat_reg} <= '0;
            state_reg <= WGAP;
          end else if (!stb_reg) begin
            // First word only: later words are launched straight out of WGAP.
            {cyc_reg, stb_reg, we_reg, sel_reg} <= {3'b111, 4'hF};
            adr_reg <= word_adr(idx_reg);
            dat_reg <= word_dat(seed_reg, idx_reg);
          end
        end
        WGAP: begin
          if (last_word) begin
            idx_reg   <= '0;
            state_reg <= READ;
            {cyc_reg, stb_reg, we_reg, sel_reg} <= {3'b110, 4'hF};
            adr_reg   <= word_adr('0);
            dat_reg   <= '0;
          end else begin
            idx_reg   <= idx_inc;
            state_reg <= WRITE;
            {cyc_reg, stb_reg, we_reg, sel_reg} <= {3'b111, 4'hF};
            adr_reg   <= word_adr(idx_inc);
            dat_reg   <= word_dat(seed_reg, idx_inc);
          end
        end
        READ: begin
          if (ack_seen) begin
            {cyc_reg, stb_reg, we_reg, sel_reg, adr_reg, dat_reg} <= '0;
            state_reg <= RGAP;
            if (wbm_dat_i != word_dat(seed_reg, idx_reg)) begin
              if (err_reg != 16'hFFFF) err_reg <= err_reg + 16'd1;
              if (err_reg == 16'd0)    fail_reg <= adr_reg;
            end
          end
        end
        RGAP: begin
          if (last_word) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            pass_reg  <= (err_reg == 16'd0) && !timeout_reg;
          end else begin
            idx_reg   <= idx_inc;
            state_reg <= READ;
            {cyc_reg, stb_reg, we_reg, sel_reg} <= {3'b110, 4'hF};
            adr_reg   <= word_adr(idx_inc);
            dat_reg   <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wbm_cyc_o   = cyc_reg;
  assign wbm_stb_o   = stb_reg;
  assign wbm_we_o    = we_reg;
  assign wbm_sel_o   = sel_reg;
  assign wbm_adr_o   = adr_reg;
  assign wbm_dat_o   = dat_reg;
  assign busy_o      = (state_reg == WRITE) || (state_reg == WGAP) ||
                       (state_reg == READ)  || (state_reg == RGAP);
  assign done_o      = done_reg;
  assign pass_o      = pass_reg;
  assign err_count_o = err_reg;
  assign fail_addr_o = fail_reg;

endmodule
